// File: rtl/cpu_pkg.sv
// Shared instruction-format constants for the CPU decode path.
// Bit positions are named here so decoder and queue agree on the field layout.
package cpu_pkg;

    localparam int INSTR_W    = 32;
    localparam int REG_ADDR_W = 4;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 28;
    localparam int OPC_HI  = 26;
    localparam int OPC_LO  = 23;

    localparam int AREG_HI = 11;
    localparam int AREG_LO = 8;
    localparam int BREG_HI = 7;
    localparam int BREG_LO = 4;
    localparam int DREG_HI = 3;
    localparam int DREG_LO = 0;

    localparam int C11_HI  = 22;
    localparam int C11_LO  = 12;
    localparam int C16_HI  = 27;
    localparam int C16_LO  = 12;
    localparam int C27_HI  = 27;
    localparam int C27_LO  = 1;

    localparam int C11_W   = C11_HI - C11_LO + 1;
    localparam int C16_W   = C16_HI - C16_LO + 1;
    localparam int C27_W   = C27_HI - C27_LO + 1;

    localparam int CE_BIT   = 27;
    localparam int HE_BIT   = 8;
    localparam int OE_BIT   = 0;
    localparam int INTF_BIT = 4;
    localparam int N1_BIT   = 0;
    localparam int N2_BIT   = 5;

endpackage

// File: rtl/instr_fifo.sv
// Instruction word FIFO: storage, wrapping pointers, exact occupancy count,
// valid/ready on both sides and a flush that overrides every handshake.
module instr_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Storage is not reset; out_valid qualifies everything read from it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Queued instruction decoder: buffers fetched words and decodes the head entry
// into register, opcode, flag and extended-constant fields.
module instr_decode_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int SEXT16 = 1,
    parameter int SEXT27 = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [INSTR_W-1:0]      in_instr,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic [3:0]              instrOP,
    output logic [3:0]              opcode,
    output logic [REG_ADDR_W-1:0]   areg,
    output logic [REG_ADDR_W-1:0]   breg,
    output logic [REG_ADDR_W-1:0]   dreg,
    output logic                    ce,
    output logic                    he,
    output logic                    oe,
    output logic                    intf,
    output logic                    n1,
    output logic                    n2,
    output logic [DATA_W-1:0]       const11,
    output logic [DATA_W-1:0]       const16,
    output logic [DATA_W-1:0]       const27,
    output logic                    is_nop
);

    logic [INSTR_W-1:0] head;
    logic [INSTR_W-1:0] hd;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head),
        .count     (count)
    );

    // Gating the word itself forces every decoded field to zero when empty.
    assign hd = out_valid ? head : '0;

    assign instrOP = hd[OP_HI:OP_LO];
    assign opcode  = hd[OPC_HI:OPC_LO];
    assign areg    = hd[AREG_HI:AREG_LO];
    assign breg    = hd[BREG_HI:BREG_LO];
    assign dreg    = hd[DREG_HI:DREG_LO];
    assign ce      = hd[CE_BIT];
    assign he      = hd[HE_BIT];
    assign oe      = hd[OE_BIT];
    assign intf    = hd[INTF_BIT];
    assign n1      = hd[N1_BIT];
    assign n2      = hd[N2_BIT];
    assign is_nop  = out_valid && (head == '0);

    always_comb begin
        const11 = '0;
        const16 = '0;
        const27 = '0;
        const11[C11_W-1:0] = hd[C11_HI:C11_LO];
        const16[C16_W-1:0] = hd[C16_HI:C16_LO];
        const27[C27_W-1:0] = hd[C27_HI:C27_LO];
        for (int i = C16_W; i < DATA_W; i++)
            const16[i] = (SEXT16 != 0) && hd[C16_HI];
        for (int i = C27_W; i < DATA_W; i++)
            const27[i] = (SEXT27 != 0) && hd[C27_HI];
    end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue with default parameters
// (DEPTH=4, DATA_W=32, SEXT16=1, SEXT27=0).
module tb_instr_decode_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    logic [3:0]  instrOP, opcode, areg, breg, dreg;
    logic        ce, he, oe, intf, n1, n2;
    logic [31:0] const11, const16, const27;
    logic        is_nop;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    instr_decode_queue dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .instrOP   (instrOP),
        .opcode    (opcode),
        .areg      (areg),
        .breg      (breg),
        .dreg      (dreg),
        .ce        (ce),
        .he        (he),
        .oe        (oe),
        .intf      (intf),
        .n1        (n1),
        .n2        (n2),
        .const11   (const11),
        .const16   (const16),
        .const27   (const27),
        .is_nop    (is_nop)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the scoreboard; fields derived straight from the word.
    task automatic check_outputs();
        logic [31:0] h;
        logic        ne;
        int          sz;
        sz = q.size();
        ne = (sz > 0);
        h  = ne ? q[0] : 32'h0;
        check_val("count",     64'(count),     64'(sz));
        check_val("in_ready",  64'(in_ready),  64'(sz != 4));
        check_val("out_valid", 64'(out_valid), 64'(ne));
        check_val("is_nop",    64'(is_nop),    64'(ne && (h == 32'h0)));
        check_val("instrOP",   64'(instrOP),   64'(h[31:28]));
        check_val("opcode",    64'(opcode),    64'(h[26:23]));
        check_val("regs",      64'({areg, breg, dreg}), 64'({h[11:8], h[7:4], h[3:0]}));
        check_val("flags",     64'({ce, he, oe, intf, n1, n2}),
                  64'({h[27], h[8], h[0], h[4], h[0], h[5]}));
        check_val("const11",   64'(const11),   64'({21'h0, h[22:12]}));
        check_val("const16",   64'(const16),   64'({{16{h[27]}}, h[27:12]}));
        check_val("const27",   64'(const27),   64'({5'h0, h[27:1]}));
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, check at negedge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic r, input logic f);
        int sz;
        in_valid  = v;
        in_instr  = w;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        sz = q.size();
        if (f) begin
            q.delete();
        end else begin
            if (r && sz > 0) void'(q.pop_front());
            if (v && sz < 4) q.push_back(w);
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        // Reset held with in_valid high: nothing may enter.
        in_valid = 1'b1;
        in_instr = 32'hDEAD_BEEF;
        #1;
        check_outputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
        check_outputs();

        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check_val("op_1234",   64'(instrOP), 64'h1);
        check_val("opc_1234",  64'(opcode),  64'h4);
        check_val("regs_1234", 64'({areg, breg, dreg}), 64'h678);
        check_val("c11_1234",  64'(const11), 64'h345);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'h8FFF_F001, 1'b0, 1'b0);
        check_val("c16_sext",  64'(const16), 64'hFFFF_FFFF);
        check_val("c27_zext",  64'(const27), 64'h07FF_F800);
        check_val("ce_oe",     64'({ce, oe}), 64'h3);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill past DEPTH; the fifth word and changes while full are ignored.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hA000_0000 + 32'(i * 32'h0111_1111), 1'b0, 1'b0);
        check_val("full_ready", 64'(in_ready), 64'h0);
        cycle(1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Steady push+pop at count 2 across pointer wrap.
        cycle(1'b1, 32'h1111_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h1111_0002, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, $urandom, 1'b1, 1'b0);
            check_val("steady_cnt", 64'(count), 64'h2);
        end

        // Flush with simultaneous push and pop at count 3.
        cycle(1'b1, 32'h2222_0003, 1'b0, 1'b0);
        check_val("pre_flush", 64'(count), 64'h3);
        cycle(1'b1, 32'h3333_0004, 1'b1, 1'b1);
        check_val("post_flush_nop", 64'(is_nop), 64'h0);

        // An all-zero word decodes as a nop.
        cycle(1'b1, 32'h0, 1'b0, 1'b0);
        check_val("nop_word", 64'(is_nop), 64'h1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 1)), (($urandom % 8) == 0) ? 32'h0 : $urandom,
                  1'($urandom_range(0, 1)), 1'(($urandom % 20) == 0));

        // Asynchronous reset between edges empties the queue immediately.
        cycle(1'b1, 32'h4444_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'h4444_0002, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        check_val("async_rst_valid", 64'(out_valid), 64'h0);
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 32'h5678_9ABC, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
